dm_port_arbiter: RTL

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_arb_pkg.sv | 37 +++
 rtl/dm_port_arbiter_if.sv | 39 +++
 rtl/dm_arb_rr.sv | 58 +++++
 rtl/dm_port_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared defaults, conflict classification and read-return source encoding
// for dm_port_arbiter. Build option: DM_ARB_FWD_EN (read/write forwarding).
package dm_arb_pkg;

  localparam int DM_AW     = 9;
  localparam int DM_DW     = 16;
  localparam int DM_RAM_AW = 8;
  localparam int CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    CF_NONE  = 2'd0,
    CF_RD_WR = 2'd1,
    CF_WR_WR = 2'd2
  } conflict_e;

  typedef enum logic [1:0] {
    RSEL_RAM  = 2'd0,
    RSEL_ZERO = 2'd1,
    RSEL_FWD  = 2'd2
  } rsel_e;

  // Two live requests hitting the same RAM word clash only if one of them writes.
  function automatic conflict_e classify(input logic req0, input logic req1,
                                         input logic we0, input logic we1,
                                         input logic same_idx);
    conflict_e kind;
    kind = CF_NONE;
    if (req0 && req1 && same_idx) begin
      if (we0 && we1)      kind = CF_WR_WR;
      else if (we0 || we1) kind = CF_RD_WR;
    end
    return kind;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester, RAM and status bundle of dm_port_arbiter; slave = arbiter side,
// master = requesters plus RAM model.
interface dm_port_arbiter_if #(
  parameter int AW     = dm_arb_pkg::DM_AW,
  parameter int DW     = dm_arb_pkg::DM_DW,
  parameter int RAM_AW = dm_arb_pkg::DM_RAM_AW
) ();

  logic              p0_req,    p1_req;
  logic              p0_we,     p1_we;
  logic [AW-1:0]     p0_addr,   p1_addr;
  logic [DW-1:0]     p0_wdata,  p1_wdata;
  logic              p0_gnt,    p1_gnt;
  logic              p0_rvalid, p1_rvalid;
  logic [DW-1:0]     p0_rdata,  p1_rdata;
  logic [RAM_AW-1:0] ram_addr_a, ram_addr_b;
  logic              ram_we_a,   ram_we_b;
  logic [DW-1:0]     ram_data_a, ram_data_b;
  logic [DW-1:0]     ram_q_a,    ram_q_b;
  logic              err;
  logic [15:0]       conflict_cnt;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  ram_q_a, ram_q_b,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    output ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
    output err, conflict_cnt
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output ram_q_a, ram_q_b,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    input  ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
    input  err, conflict_cnt
  );

endinterface

// File: rtl/dm_arb_rr.sv
// Conflict detection, round-robin pointer and saturating conflict counter.
// With DM_ARB_FWD_EN defined, read/write clashes are granted to both sides.
module dm_arb_rr
  import dm_arb_pkg::*;
#(
  parameter int RAM_AW = DM_RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [RAM_AW-1:0] idx0,
  input  logic [RAM_AW-1:0] idx1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              fwd,
  output logic [CNT_W-1:0]  conflict_cnt
);

`ifdef DM_ARB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  conflict_e        kind;
  logic             arb;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal driven here gets a value on every path so no latch is inferred.
  always_comb begin
    kind  = classify(req0, req1, we0, we1, idx0 == idx1);
    fwd   = FWD_EN && (kind == CF_RD_WR);
    arb   = (kind != CF_NONE) && !fwd;
    gnt0  = req0 && (!arb || !rr_q);
    gnt1  = req1 && (!arb ||  rr_q);
    // The loser of an arbitrated clash owns the next one (1 = p1).
    rr_d  = arb ? gnt0 : rr_q;
    cnt_d = (arb && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  // NOTE: flops use non-blocking assignment so each samples its pre-edge inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// Two requesters onto a dual-port RAM (p0 -> A, p1 -> B) with same-word
// arbitration, out-of-range trapping and one-cycle read return.
// Build option: DM_ARB_FWD_EN (see dm_arb_rr).
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW     = DM_AW,
  parameter int DW     = DM_DW,
  parameter int RAM_AW = DM_RAM_AW
) (
  input logic               clk,
  input logic               rst,
  dm_port_arbiter_if.slave  bus
);

  typedef struct packed {
    logic          rvalid;
    rsel_e         sel;
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] hold;
  } ret_t;

  logic [1:0]    req, we, oor, gnt, ram_we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] ram_q [2];
  logic [DW-1:0] rdata [2];
  logic          fwd;
  logic          err_q, err_d;
  ret_t          ret_q [2];
  ret_t          ret_d [2];

  always_comb begin
    req      = {bus.p1_req, bus.p0_req};
    we       = {bus.p1_we,  bus.p0_we};
    addr[0]  = bus.p0_addr;
    addr[1]  = bus.p1_addr;
    wdata[0] = bus.p0_wdata;
    wdata[1] = bus.p1_wdata;
    ram_q[0] = bus.ram_q_a;
    ram_q[1] = bus.ram_q_b;
    for (int i = 0; i < 2; i++) begin
      oor[i] = (addr[i] >> RAM_AW) != '0;
    end
  end

  dm_arb_rr #(.RAM_AW(RAM_AW)) u_rr (
    .clk          (clk),
    .rst          (rst),
    .req0         (req[0]),
    .req1         (req[1]),
    .we0          (we[0]),
    .we1          (we[1]),
    .idx0         (addr[0][RAM_AW-1:0]),
    .idx1         (addr[1][RAM_AW-1:0]),
    .gnt0         (gnt[0]),
    .gnt1         (gnt[1]),
    .fwd          (fwd),
    .conflict_cnt (bus.conflict_cnt)
  );

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      // Out-of-range accesses are accepted but must never reach the RAM.
      ram_we[i] = req[i] && gnt[i] && we[i] && !oor[i];
      if (req[i] && gnt[i] && oor[i]) err_d = 1'b1;

      if (!ret_q[i].rvalid) begin
        rdata[i] = ret_q[i].hold;
      end else begin
        case (ret_q[i].sel)
          RSEL_ZERO: rdata[i] = '0;
          RSEL_FWD:  rdata[i] = ret_q[i].fwd_data;
          default:   rdata[i] = ram_q[i];
        endcase
      end

      ret_d[i].rvalid   = req[i] && gnt[i] && !we[i];
      ret_d[i].sel      = oor[i] ? RSEL_ZERO : (fwd ? RSEL_FWD : RSEL_RAM);
      ret_d[i].fwd_data = (i == 0) ? wdata[1] : wdata[0];
      ret_d[i].hold     = rdata[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q[0] <= '0;
      ret_q[1] <= '0;
      err_q    <= 1'b0;
    end else begin
      ret_q[0] <= ret_d[0];
      ret_q[1] <= ret_d[1];
      err_q    <= err_d;
    end
  end

  assign bus.p0_gnt     = gnt[0];
  assign bus.p1_gnt     = gnt[1];
  assign bus.p0_rvalid  = ret_q[0].rvalid;
  assign bus.p1_rvalid  = ret_q[1].rvalid;
  assign bus.p0_rdata   = rdata[0];
  assign bus.p1_rdata   = rdata[1];
  assign bus.ram_addr_a = addr[0][RAM_AW-1:0];
  assign bus.ram_addr_b = addr[1][RAM_AW-1:0];
  assign bus.ram_we_a   = ram_we[0];
  assign bus.ram_we_b   = ram_we[1];
  assign bus.ram_data_a = wdata[0];
  assign bus.ram_data_b = wdata[1];
  assign bus.err        = err_q;

endmodule
